// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters (fetch, load/store), the arbiter and a shared single-port memory.
// Handshake: a requester raises *_req and holds it (with stable address/data) until it sees a one-cycle *_ack;
// the arbiter holds mem_req and its latched address/data until mem_ack or timeout, then drops mem_req.
interface mem_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [3:0]  data_sel;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;

    logic        err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        stallreq;
    logic [1:0]  state;

    // Arbiter side.
    modport master (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_addr, data_sel, data_wdata,
        input  mem_rdata, mem_ack,
        output inst_ack, inst_rdata, data_ack, data_rdata, err,
        output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        output stallreq, state
    );

    // Requester/memory side.
    modport slave (
        output inst_req, inst_addr,
        output data_req, data_we, data_addr, data_sel, data_wdata,
        output mem_rdata, mem_ack,
        input  inst_ack, inst_rdata, data_ack, data_rdata, err,
        input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        input  stallreq, state
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared single-port memory: alternating priority on ties,
// latched memory request, per-transaction timeout with error flag.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_data_q, last_data_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_sel_q, mem_sel_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        inst_ack_q, inst_ack_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic        data_ack_q, data_ack_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        err_q, err_d;

    logic        grant_inst;
    logic        timed_out;

    // On a tie the requester that was not served last wins.
    assign grant_inst = bus.inst_req && (!bus.data_req || last_data_q);
    assign timed_out  = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_sel_d    = mem_sel_q;
        mem_wdata_d  = mem_wdata_q;
        inst_ack_d   = 1'b0;
        inst_rdata_d = 32'h0;
        data_ack_d   = 1'b0;
        data_rdata_d = 32'h0;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_inst) begin
                    state_d     = BUSY_I;
                    last_data_d = 1'b0;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.inst_addr;
                    mem_sel_d   = 4'hF;
                    mem_wdata_d = 32'h0;
                end else if (bus.data_req) begin
                    state_d     = BUSY_D;
                    last_data_d = 1'b1;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.data_we;
                    mem_addr_d  = bus.data_addr;
                    mem_sel_d   = bus.data_sel;
                    mem_wdata_d = bus.data_wdata;
                end
            end
            BUSY_I, BUSY_D: begin
                // A mem_ack on the final counted cycle still wins over the timeout.
                if (bus.mem_ack || timed_out) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    err_d     = !bus.mem_ack;
                    if (state_q == BUSY_I) begin
                        inst_ack_d   = 1'b1;
                        inst_rdata_d = bus.mem_ack ? bus.mem_rdata : 32'h0;
                    end else begin
                        data_ack_d   = 1'b1;
                        data_rdata_d = bus.mem_ack ? bus.mem_rdata : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_data_q  <= 1'b0;
            cnt_q        <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_sel_q    <= 4'h0;
            mem_wdata_q  <= 32'h0;
            inst_ack_q   <= 1'b0;
            inst_rdata_q <= 32'h0;
            data_ack_q   <= 1'b0;
            data_rdata_q <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_sel_q    <= mem_sel_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_ack_q   <= inst_ack_d;
            inst_rdata_q <= inst_rdata_d;
            data_ack_q   <= data_ack_d;
            data_rdata_q <= data_rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_sel    = mem_sel_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.inst_ack   = inst_ack_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.data_ack   = data_ack_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.err        = err_q;
    assign bus.state      = state_q;

    assign bus.stallreq = (bus.inst_req & ~inst_ack_q) | (bus.data_req & ~data_ack_q);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum BUSY cycles waiting for mem_ack before abort; legal range 1..255.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held high until inst_ack.
- inst_addr  in  32  fetch address; stable while inst_req high.
- inst_ack  out  1  one-cycle fetch completion pulse.
- inst_rdata  out  32  fetch data; valid with inst_ack.
- data_req  in  1  load/store request; held high until data_ack.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  32  load/store address.
- data_sel  in  4  byte enables.
- data_wdata  in  32  store data.
- data_ack  out  1  one-cycle load/store completion pulse.
- data_rdata  out  32  load data; valid with data_ack.
- err  out  1  high with an ack when that transaction timed out.
- mem_req  out  1  request to the shared single-port memory.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_sel  out  4  memory byte enables.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid when mem_ack high.
- mem_ack  in  1  memory completion; may arrive 1 or more cycles after mem_req rises.
- stallreq  out  1  combinational: (inst_req & ~inst_ack) | (data_req & ~data_ack).

Function
REQ-003 FSM states IDLE, BUSY_I, BUSY_D, RESP; all outputs except stallreq registered.
REQ-004 IDLE, no request: remain IDLE; mem_req = 0.
REQ-005 IDLE, exactly one request: grant it; next cycle state is BUSY_I or BUSY_D.
REQ-006 IDLE, both requests: grant the requester not granted last (last_grant register); the loser waits, holding its request.
REQ-007 On grant, mem_addr, mem_we, mem_sel and mem_wdata SHALL latch the winner's signals (inst grant: mem_we = 0, mem_sel = 4'hF, mem_wdata = 0); mem_req = 1 from the first BUSY cycle.
REQ-008 Latched memory outputs SHALL stay stable for the whole BUSY period, whatever the requester inputs do.
REQ-009 BUSY, mem_ack = 1: next cycle state RESP, mem_req = 0, granted requester's ack = 1, its rdata = mem_rdata as sampled, err = 0.
REQ-010 A timeout counter SHALL clear on grant and increment each BUSY cycle without mem_ack.
REQ-011 Timeout: when the counter reaches TIMEOUT without mem_ack, next state RESP, mem_req = 0, ack = 1, err = 1, rdata = 32'h0.
REQ-012 mem_ack on the same cycle the counter reaches TIMEOUT SHALL count as success (err = 0).
REQ-013 RESP lasts exactly one cycle: no new grant; all acks and err return to 0; then state IDLE.
REQ-014 Non-granted requester's ack and rdata SHALL stay 0 throughout.
REQ-015 mem_ack in IDLE or RESP SHALL be ignored.
REQ-016 Latency: request seen in IDLE at cycle 0 -> mem_req at cycle 1 -> mem_ack at cycle k (k >= 1) -> ack at cycle k+1 -> IDLE at cycle k+2.
REQ-017 Back-to-back requests from one requester with no contention SHALL be granted from IDLE every k+2 cycles.

Reset
REQ-018 When rst = 1 at a rising edge: state IDLE; last_grant = inst, so data wins the first tie; counter = 0; all registered outputs = 0.
REQ-019 Reset mid-transaction SHALL abort it: mem_req = 0 the next cycle, no ack and no err for the aborted request.

Verification
REQ-020 Single fetch: inst_req with inst_addr = 32'h00000004; memory acks 2 cycles after mem_req with 32'h34011100 -> mem_addr = 32'h00000004, mem_we = 0; inst_ack one cycle with inst_rdata = 32'h34011100; err = 0.
REQ-021 Tie after reset: inst_req and data_req rise together, memory latency 1 -> data served first, then inst; next tie served inst first.
REQ-022 Store: data_we = 1, data_addr = 32'h00000010, data_sel = 4'b0011, data_wdata = 32'h0000FF00 -> mem outputs match exactly; data_ack pulses; data_rdata = 0.
REQ-023 Timeout: TIMEOUT = 3, memory never acks -> mem_req high 3 cycles, then data_ack = 1, err = 1, data_rdata = 0; next request served normally.
REQ-024 Reset mid-BUSY: rst asserted on second BUSY cycle -> mem_req = 0, no ack, state IDLE; pending request then re-granted.
REQ-025 stallreq: high from inst_req rise until the inst_ack cycle inclusive of request-only cycles; low on the inst_ack cycle.
